mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output handshake.
- Two modes: manual, where the channel comes from `sel`, and scan, where an internal round-robin pointer picks the channel and advances on every accepted word.
- Successor to the team's single-bit gate-level 2:1 select logic.
- Feeds downstream datapath stages that need time-multiplexed access to several sources.

Parameters:
- WIDTH, 8: data bits per channel.
- CHANNELS, 4: number of input channels, minimum 2, need not be a power of 2.
- SEL_W, $clog2(CHANNELS): width of the select and pointer signals.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = manual, 1 = scan.
- sel  input  SEL_W  manual channel select.
- in_data  input  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1  input word available.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  channel that produced out_data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data.
- sel_err  output  1  registered flag: last captured manual sel was >= CHANNELS.
- err_cnt  output  16  self-check mismatch count (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - out_data = 0, out_sel = 0, out_valid = 0, sel_err = 0.
  - scan_ptr = 0, mode_q = 0, err_cnt = 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept: out_data, out_sel and sel_err load on the next rising edge; out_valid = 1. Latency is 1 cycle.
  - out_valid clears when out_ready = 1 and there is no accept in the same cycle.
  - Simultaneous drain and accept: the new word replaces the old one and out_valid stays 1, so throughput is 1 word/cycle.
  - While out_valid = 1 and out_ready = 0: all outputs hold stable and in_ready = 0.
- Channel selection:
  - Manual: ch = sel.
  - Scan: ch = scan_ptr.
- Out-of-range sel (manual mode, sel >= CHANNELS):
  - out_data = 0, out_sel = sel, sel_err = 1.
  - The word is still accepted and presented.
- Scan pointer:
  - Increments only on accept in scan mode.
  - Wraps from CHANNELS-1 to 0; it never reaches an illegal value.
- Mode handling:
  - mode_q registers mode each cycle.
  - On the cycle where mode = 1 and mode_q = 0, scan_ptr is treated as 0. If that cycle accepts, channel 0 is captured and the pointer becomes 1.
  - Changing mode while out_valid = 1 does not alter the held word.
- rst asserted mid-transfer: the held word is discarded, out_valid drops immediately, and the pointer returns to 0.

Optional Feature:
- Macro: MUX_SCAN_SELF_CHECK_EN.
- Defined:
  - An independent reference path computes the expected word on accept: a loop-based compare over all channels, not an indexed part-select.
  - The expected word is registered alongside out_data.
  - Each cycle with out_valid && out_ready and expected != out_data, err_cnt increments, saturating at 16'hFFFF.
- Undefined: reference path absent; err_cnt tied to 0.

Decomposition:
- Package mux_scan_pkg holds:
  - mode_e enum {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1}.
  - ERR_CNT_W = 16.
  - ERR_CNT_MAX constant.
- One sub-module, mux_scan_sel: purely combinational WIDTH/CHANNELS selector that outputs a zero word and an out-of-range flag.
- mux_scan instantiates mux_scan_sel and holds the handshake register, the scan pointer and the self-check logic.

Test Plan:
- Reset with the bus driven: rst = 1 while in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 1; after release, the first accept appears 1 cycle later.
- Manual mode, CHANNELS = 4, WIDTH = 8, in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA}, sel = 2, out_ready = 1 -> out_data = 8'hCC, out_sel = 2 next cycle.
- Scan mode, 6 back-to-back accepts with out_ready = 1 -> out_sel sequence 0, 1, 2, 3, 0, 1 with matching data, one word per cycle.
- Backpressure: out_ready = 0 for 3 cycles after a word is loaded -> in_ready = 0, out_data held; the first cycle with out_ready = 1 drains and accepts the next word.
- CHANNELS = 3, manual sel = 3 -> out_data = 0, sel_err = 1, out_valid = 1.
- With MUX_SCAN_SELF_CHECK_EN defined, force out_data to corrupt for 1 beat -> err_cnt = 1. Without the macro -> err_cnt = 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan registered N-channel multiplexer.
package mux_scan_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int                   ERR_CNT_W   = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/mux_scan_sel.sv
// Combinational channel selector: returns the chosen word, or zero plus an
// out-of-range flag when the channel index is not below CHANNELS.
module mux_scan_sel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]          i_ch,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_oor
);

    localparam logic [SEL_W:0] CH_COUNT = (SEL_W + 1)'(CHANNELS);

    logic [WIDTH-1:0] w_chData [CHANNELS];
    logic             w_inRange;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_split
        assign w_chData[k] = i_data[k*WIDTH +: WIDTH];
    end

    // Index into the channel array only once the channel is known to be legal.
    assign w_inRange = ({1'b0, i_ch} < CH_COUNT);
    assign o_oor     = !w_inRange;
    assign o_data    = w_inRange ? w_chData[i_ch] : '0;

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with valid/ready output, manual or round-robin
// scan selection. Optional reference self-check: define MUX_SCAN_SELF_CHECK_EN.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [CHANNELS*WIDTH-1:0] i_in_data,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    output logic [WIDTH-1:0]          o_out_data,
    output logic [SEL_W-1:0]          o_out_sel,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic                      o_sel_err,
    output logic [ERR_CNT_W-1:0]      o_err_cnt
);

    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

    mode_e            w_mode;
    mode_e            r_modeQ;
    logic [SEL_W-1:0] r_scanPtr;
    logic [SEL_W-1:0] w_ptrEff;
    logic [SEL_W-1:0] w_ptrNext;
    logic [SEL_W-1:0] w_ch;
    logic [WIDTH-1:0] w_selData;
    logic             w_oor;
    logic             w_accept;

    logic [WIDTH-1:0] r_outData;
    logic [SEL_W-1:0] r_outSel;
    logic             r_outValid;
    logic             r_selErr;

    assign w_mode     = mode_e'(i_mode);
    assign o_in_ready = !r_outValid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;

    // Entering scan mode restarts the round-robin from channel 0.
    assign w_ptrEff = (w_mode == MODE_SCAN && r_modeQ == MODE_MANUAL) ? '0 : r_scanPtr;
    assign w_ch     = (w_mode == MODE_SCAN) ? w_ptrEff : i_sel;

    always_comb begin
        w_ptrNext = w_ptrEff;
        if (w_accept && w_mode == MODE_SCAN) begin
            w_ptrNext = (w_ptrEff == PTR_LAST) ? '0 : w_ptrEff + SEL_W'(1);
        end
    end

    mux_scan_sel #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_sel (
        .i_data (i_in_data),
        .i_ch   (w_ch),
        .o_data (w_selData),
        .o_oor  (w_oor)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_modeQ    <= MODE_MANUAL;
            r_scanPtr  <= '0;
            r_outData  <= '0;
            r_outSel   <= '0;
            r_outValid <= 1'b0;
            r_selErr   <= 1'b0;
        end else begin
            r_modeQ   <= w_mode;
            r_scanPtr <= w_ptrNext;
            if (w_accept) begin
                r_outData  <= w_selData;
                r_outSel   <= w_ch;
                r_selErr   <= w_oor;
                r_outValid <= 1'b1;
            end else if (i_out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign o_out_data  = r_outData;
    assign o_out_sel   = r_outSel;
    assign o_out_valid = r_outValid;
    assign o_sel_err   = r_selErr;

`ifdef MUX_SCAN_SELF_CHECK_EN
    logic [WIDTH-1:0]     w_refData;
    logic [WIDTH-1:0]     r_expData;
    logic [ERR_CNT_W-1:0] r_errCnt;

    // Reference path deliberately uses a compare loop rather than indexing.
    always_comb begin
        w_refData = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_ch == SEL_W'(k)) begin
                w_refData = i_in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expData <= '0;
            r_errCnt  <= '0;
        end else begin
            if (w_accept) begin
                r_expData <= w_refData;
            end
            if (r_outValid && i_out_ready && r_expData != r_outData && r_errCnt != ERR_CNT_MAX) begin
                r_errCnt <= r_errCnt + ERR_CNT_W'(1);
            end
        end
    end

    assign o_err_cnt = r_errCnt;
`else
    assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Directed testbench for mux_scan: 4-channel and 3-channel instances.
module tb_mux_scan;
    import mux_scan_pkg::*;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic [7:0]  expData;
        logic [1:0]  expSel;
        logic        expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mode4 = 1'b0;
    logic [1:0]  sel4 = 2'd1;
    logic [31:0] data4 = 32'hDDCCBBAA;
    logic        valid4 = 1'b1;
    logic        inReady4;
    logic [7:0]  outData4;
    logic [1:0]  outSel4;
    logic        outValid4;
    logic        outReady4 = 1'b1;
    logic        selErr4;
    logic [15:0] errCnt4;

    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;
    logic [23:0] data3 = 24'h332211;
    logic        valid3 = 1'b0;
    logic        inReady3;
    logic [7:0]  outData3;
    logic [1:0]  outSel3;
    logic        outValid3;
    logic        outReady3 = 1'b1;
    logic        selErr3;
    logic [15:0] errCnt3;

    int testsRun = 0;
    int failCount = 0;

    mux_scan #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk(clk), .rst(rst), .i_mode(mode4), .i_sel(sel4), .i_in_data(data4),
        .i_in_valid(valid4), .o_in_ready(inReady4), .o_out_data(outData4),
        .o_out_sel(outSel4), .o_out_valid(outValid4), .i_out_ready(outReady4),
        .o_sel_err(selErr4), .o_err_cnt(errCnt4)
    );

    mux_scan #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .i_mode(mode3), .i_sel(sel3), .i_in_data(data3),
        .i_in_valid(valid3), .o_in_ready(inReady3), .o_out_data(outData3),
        .o_out_sel(outSel3), .o_out_valid(outValid3), .i_out_ready(outReady3),
        .o_sel_err(selErr3), .o_err_cnt(errCnt3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive dut4 on the falling edge, then sample just after the next rising edge.
    task automatic applyStimulus(input logic mode, input logic [1:0] sel, input logic valid, input logic ready);
        @(negedge clk);
        mode4     = mode;
        sel4      = sel;
        valid4    = valid;
        outReady4 = ready;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [5];
    logic [7:0] scanExp [4];

    initial begin
        vecs[0] = '{sel: 2'd2, data: 32'hDDCCBBAA, expData: 8'hCC, expSel: 2'd2, expErr: 1'b0};
        vecs[1] = '{sel: 2'd0, data: 32'hDDCCBBAA, expData: 8'hAA, expSel: 2'd0, expErr: 1'b0};
        vecs[2] = '{sel: 2'd3, data: 32'hDDCCBBAA, expData: 8'hDD, expSel: 2'd3, expErr: 1'b0};
        vecs[3] = '{sel: 2'd1, data: 32'h12345678, expData: 8'h56, expSel: 2'd1, expErr: 1'b0};
        vecs[4] = '{sel: 2'd3, data: 32'hF00FA55A, expData: 8'hF0, expSel: 2'd3, expErr: 1'b0};
        scanExp[0] = 8'hAA;
        scanExp[1] = 8'hBB;
        scanExp[2] = 8'hCC;
        scanExp[3] = 8'hDD;

        // Reset held while the input bus is active.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(outValid4), 32'h0);
        checkOutput("rst_out_data", 32'(outData4), 32'h0);
        checkOutput("rst_out_sel", 32'(outSel4), 32'h0);
        checkOutput("rst_sel_err", 32'(selErr4), 32'h0);
        checkOutput("rst_in_ready", 32'(inReady4), 32'h1);
        checkOutput("rst_err_cnt", 32'(errCnt4), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_valid", 32'(outValid4), 32'h1);
        checkOutput("first_data", 32'(outData4), 32'hBB);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data4 = vecs[i].data;
            applyStimulus(1'b0, vecs[i].sel, 1'b1, 1'b1);
            checkOutput($sformatf("vec%0d_data", i), 32'(outData4), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_sel", i), 32'(outSel4), 32'(vecs[i].expSel));
            checkOutput($sformatf("vec%0d_err", i), 32'(selErr4), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_valid", i), 32'(outValid4), 32'h1);
        end

        // Scan: restarts at channel 0 on entry, one word per cycle, wraps after 3.
        data4 = 32'hDDCCBBAA;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b1, 1'b1);
            checkOutput($sformatf("scan%0d_sel", i), 32'(outSel4), 32'(i % 4));
            checkOutput($sformatf("scan%0d_data", i), 32'(outData4), 32'(scanExp[i % 4]));
            checkOutput($sformatf("scan%0d_valid", i), 32'(outValid4), 32'h1);
        end

        // Backpressure while switching back to manual: held word must not change.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
            checkOutput($sformatf("bp%0d_in_ready", i), 32'(inReady4), 32'h0);
            checkOutput($sformatf("bp%0d_data", i), 32'(outData4), 32'hBB);
            checkOutput($sformatf("bp%0d_sel", i), 32'(outSel4), 32'h1);
            checkOutput($sformatf("bp%0d_valid", i), 32'(outValid4), 32'h1);
        end
        applyStimulus(1'b0, 2'd2, 1'b1, 1'b1);
        checkOutput("bp_release_data", 32'(outData4), 32'hCC);
        checkOutput("bp_release_sel", 32'(outSel4), 32'h2);
        applyStimulus(1'b0, 2'd2, 1'b0, 1'b1);
        checkOutput("drain_valid", 32'(outValid4), 32'h0);

        // Three-channel instance: illegal manual select still yields a word.
        @(negedge clk);
        sel3   = 2'd3;
        valid3 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ch3_oor_data", 32'(outData3), 32'h0);
        checkOutput("ch3_oor_err", 32'(selErr3), 32'h1);
        checkOutput("ch3_oor_valid", 32'(outValid3), 32'h1);
        checkOutput("ch3_oor_sel", 32'(outSel3), 32'h3);
        @(negedge clk);
        sel3 = 2'd2;
        @(posedge clk);
        #1;
        checkOutput("ch3_legal_data", 32'(outData3), 32'h33);
        checkOutput("ch3_legal_err", 32'(selErr3), 32'h0);
        @(negedge clk);
        valid3 = 1'b0;

        // Reset during a stalled transfer drops the word immediately.
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("stall_valid", 32'(outValid4), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(outValid4), 32'h0);
        checkOutput("midrst_data", 32'(outData4), 32'h0);
        checkOutput("midrst_in_ready", 32'(inReady4), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
        checkOutput("post_rst_scan0", 32'(outSel4), 32'h0);
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
        checkOutput("post_rst_scan1", 32'(outSel4), 32'h1);
        checkOutput("post_rst_scan1_data", 32'(outData4), 32'hBB);

`ifdef MUX_SCAN_SELF_CHECK_EN
        checkOutput("err_cnt_clean", 32'(errCnt4), 32'h0);
        applyStimulus(1'b0, 2'd3, 1'b1, 1'b0);
        @(negedge clk);
        force dut4.r_outData = 8'h5A;
        valid4    = 1'b0;
        outReady4 = 1'b1;
        @(posedge clk);
        #1;
        release dut4.r_outData;
        checkOutput("err_cnt_corrupt", 32'(errCnt4), 32'h1);
`else
        checkOutput("err_cnt_tied", 32'(errCnt4), 32'h0);
        checkOutput("err_cnt_tied3", 32'(errCnt3), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
